apb_gpio_arbiter: RTL
=====================

Name: apb_gpio_arbiter

Overview:
- Two-requester APB master and arbiter that shares a single APB GPIO slave (MODE=0, DIRECTION=1, OUTPUT=2, INPUT=3 register map) between two on-chip clients, e.g. the CPU bridge and a DMA/test sequencer.
- Accepts simple valid/ready requests, runs a round-robin choice, and drives the APB SETUP/ACCESS phases.
- Honours slave wait states (PREADY low), enforces a wait-state timeout, and returns a one-cycle response with read data and an error flag to the originating client.

Parameters:
- PDATA_SIZE, 32, APB data width; must be a multiple of 8.
- PADDR_SIZE, 4, APB address width.
- NUM_REGS, 4, count of valid slave addresses (0..NUM_REGS-1).
- TIMEOUT, 16, maximum consecutive ACCESS cycles with PREADY low before abort; must be at least 2.

Ports:
- APB_CLK  in  1  clock
- APB_PRESET_n  in  1  reset
- req0_valid / req1_valid  in  1  client request pending; held until accepted
- req0_write / req1_write  in  1  1=write, 0=read
- req0_addr / req1_addr  in  PADDR_SIZE  register address
- req0_wdata / req1_wdata  in  PDATA_SIZE  write data
- req0_strb / req1_strb  in  PDATA_SIZE/8  byte strobes
- req0_ready / req1_ready  out  1  request accepted this cycle
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  PDATA_SIZE  read data, valid with rsp_valid
- rsp0_err / rsp1_err  out  1  error, valid with rsp_valid
- APB_PSEL  out  1  slave select
- APB_PENABLE  out  1  access phase
- APB_PADDR  out  PADDR_SIZE  address
- APB_PWRITE  out  1  direction
- APB_PSTRB  out  PDATA_SIZE/8  strobes; forced to 0 on reads
- APB_PWDATA  out  PDATA_SIZE  write data
- APB_PRDATA  in  PDATA_SIZE  slave read data
- APB_PREADY  in  1  slave ready / wait state
- APB_PSLVERR  in  1  slave error

Behaviour:
- Clock and reset: reset APB_PRESET_n, asynchronous, active-low; clock APB_CLK. All state is updated on the rising edge of APB_CLK.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Round-robin pointer favours requester 0.
  - Timeout counter is 0.
- Reset mid-transfer: the transfer is dropped, PSEL/PENABLE fall immediately, and no response is generated.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any reqN_valid is high, the winner's reqN_ready is asserted combinationally in the same cycle, and its write, addr, wdata and strb are captured plus the winner ID.
  - If the address is below NUM_REGS, next state is SETUP.
  - If the address is NUM_REGS or above, no APB cycle is run. Next cycle: rspN_valid=1, rspN_err=1, rdata=0. State stays IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The pointer updates on every grant, including decode errors.
- SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PSTRB/PWDATA from the capture registers. Lasts exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, with all address and data outputs held stable.
  - If PREADY is 1 at the clock edge, the transfer completes. Next cycle: rspN_valid=1, rspN_err=PSLVERR, rspN_rdata=PRDATA for reads and 0 for writes. State goes to IDLE with PSEL=0 and PENABLE=0.
  - If PREADY is 0, the timeout counter increments.
  - When the counter reaches TIMEOUT with PREADY still 0, the transfer aborts: PSEL/PENABLE drop, rspN_valid=1, rspN_err=1, rdata=0, state goes to IDLE.
  - The counter clears on leaving ACCESS.
- Latency and throughput:
  - Grant in cycle T, SETUP in T+1, ACCESS in T+2.
  - With zero wait states, the response pulses in T+3, and a new grant is allowed in that same T+3 cycle.
  - Peak rate is one transfer per 3 cycles; each wait state adds 1 cycle.
- Responses:
  - Only the originating requester's rsp_valid pulses.
  - rspN_rdata and rspN_err hold their values until the next response to that requester.
- Back-pressure: reqN_ready is 0 outside IDLE. A requester that keeps valid high is guaranteed a grant within one other transfer, so it cannot starve.
- Data path: no byte-lane arithmetic is performed; strobes and data pass through unchanged. APB_PSTRB is 0 whenever PWRITE=0.

Test Plan:
- Single write, zero wait: req0 write addr=2, wdata=0x0000_00A5, strb=0x1 → PSEL high T+1, PENABLE high T+2, PWDATA=0xA5, PSTRB=0x1; rsp0_valid T+3 with err=0; rsp1_valid stays 0.
- Read with wait states: req1 read addr=3, slave holds PREADY low 3 ACCESS cycles then returns PRDATA=0x1234_5678 → ACCESS lasts 4 cycles with address stable; rsp1_rdata=0x12345678, err=0; PSTRB=0 throughout.
- Simultaneous requests: both valid every cycle for 4 transfers from reset → grant order 0,1,0,1; no back-to-back grants to the same requester.
- Timeout: PREADY stuck low, TIMEOUT=16 → PSEL/PENABLE drop after 16 ACCESS cycles; rsp err=1, rdata=0; the next request completes normally.
- Decode error and slave error: req0 addr=5 → no PSEL; rsp0 err=1 one cycle after grant. Then write addr=1 with PSLVERR=1 at completion → rsp0 err=1.
- Reset mid-ACCESS: assert APB_PRESET_n low while in ACCESS → PSEL, PENABLE and rsp* go to 0 asynchronously; after release, req0 wins the first simultaneous arbitration.

Source files
------------

// File: rtl/apb_gpio_arbiter.sv
// Two-client APB master for a shared GPIO slave.
// Round-robin grant in IDLE, SETUP/ACCESS sequencing, wait-state timeout,
// and a one-cycle response pulse back to the client that issued the request.
module apb_gpio_arbiter #(
    parameter int PDATA_SIZE = 32,
    parameter int PADDR_SIZE = 4,
    parameter int NUM_REGS   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    APB_CLK,
    input  logic                    APB_PRESET_n,

    input  logic                    req0_valid,
    input  logic                    req0_write,
    input  logic [PADDR_SIZE-1:0]   req0_addr,
    input  logic [PDATA_SIZE-1:0]   req0_wdata,
    input  logic [PDATA_SIZE/8-1:0] req0_strb,
    output logic                    req0_ready,
    output logic                    rsp0_valid,
    output logic [PDATA_SIZE-1:0]   rsp0_rdata,
    output logic                    rsp0_err,

    input  logic                    req1_valid,
    input  logic                    req1_write,
    input  logic [PADDR_SIZE-1:0]   req1_addr,
    input  logic [PDATA_SIZE-1:0]   req1_wdata,
    input  logic [PDATA_SIZE/8-1:0] req1_strb,
    output logic                    req1_ready,
    output logic                    rsp1_valid,
    output logic [PDATA_SIZE-1:0]   rsp1_rdata,
    output logic                    rsp1_err,

    output logic                    APB_PSEL,
    output logic                    APB_PENABLE,
    output logic [PADDR_SIZE-1:0]   APB_PADDR,
    output logic                    APB_PWRITE,
    output logic [PDATA_SIZE/8-1:0] APB_PSTRB,
    output logic [PDATA_SIZE-1:0]   APB_PWDATA,
    input  logic [PDATA_SIZE-1:0]   APB_PRDATA,
    input  logic                    APB_PREADY,
    input  logic                    APB_PSLVERR
);

    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    // One extra bit so NUM_REGS == 2**PADDR_SIZE still compares correctly.
    localparam logic [PADDR_SIZE:0] L_NREGS = (PADDR_SIZE + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // Requests gathered into per-client arrays, index = client id.
    logic [1:0]                 w_req_valid;
    logic [1:0]                 w_req_write;
    logic [1:0][PADDR_SIZE-1:0] w_req_addr;
    logic [1:0][PDATA_SIZE-1:0] w_req_wdata;
    logic [1:0][STRB_W-1:0]     w_req_strb;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_req_write = {req1_write, req0_write};
    assign w_req_addr  = {req1_addr,  req0_addr};
    assign w_req_wdata = {req1_wdata, req0_wdata};
    assign w_req_strb  = {req1_strb,  req0_strb};

    state_t                  r_state, w_next;
    logic                    r_last;   // id granted most recently
    logic                    r_id;     // id owning the transfer in flight
    logic                    r_write;
    logic [PADDR_SIZE-1:0]   r_addr;
    logic [PDATA_SIZE-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [CNT_W-1:0]        r_cnt;

    logic                    w_gnt, w_gnt_id, w_dec_ok;
    logic                    w_done, w_abort;
    logic                    w_rsp_ev, w_rsp_id, w_rsp_err;
    logic [PDATA_SIZE-1:0]   w_rsp_data;

    logic [1:0]                 r_rsp_valid;
    logic [1:0]                 r_rsp_err;
    logic [1:0][PDATA_SIZE-1:0] r_rsp_rdata;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = 1'b0;
        if (r_state == IDLE && |w_req_valid) begin
            w_gnt    = 1'b1;
            w_gnt_id = (&w_req_valid) ? ~r_last : w_req_valid[1];
        end
    end

    assign w_dec_ok   = {1'b0, w_req_addr[w_gnt_id]} < L_NREGS;
    assign req0_ready = w_gnt & ~w_gnt_id;
    assign req1_ready = w_gnt &  w_gnt_id;

    // Next-state logic; completion and timeout are decided in ACCESS only.
    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            IDLE:   if (w_gnt && w_dec_ok) w_next = SETUP;
            SETUP:  w_next = ACCESS;
            ACCESS: begin
                if (APB_PREADY) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge APB_CLK or negedge APB_PRESET_n) begin
        if (!APB_PRESET_n) r_state <= IDLE;
        else               r_state <= w_next;
    end

    // Round-robin pointer; reset value makes client 0 win the first tie.
    always_ff @(posedge APB_CLK or negedge APB_PRESET_n) begin
        if (!APB_PRESET_n) r_last <= 1'b1;
        else if (w_gnt)    r_last <= w_gnt_id;
    end

    // Capture the winning request; these registers drive the APB bus directly.
    always_ff @(posedge APB_CLK or negedge APB_PRESET_n) begin
        if (!APB_PRESET_n) begin
            r_id    <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_gnt) begin
            r_id    <= w_gnt_id;
            r_write <= w_req_write[w_gnt_id];
            r_addr  <= w_req_addr[w_gnt_id];
            r_wdata <= w_req_wdata[w_gnt_id];
            r_strb  <= w_req_strb[w_gnt_id];
        end
    end

    // Wait-state counter: counts PREADY-low ACCESS cycles, cleared otherwise.
    always_ff @(posedge APB_CLK or negedge APB_PRESET_n) begin
        if (!APB_PRESET_n)
            r_cnt <= '0;
        else if (r_state == ACCESS && !APB_PREADY && !w_abort)
            r_cnt <= r_cnt + CNT_W'(1);
        else
            r_cnt <= '0;
    end

    // A response is due after a decode error, a completion, or a timeout.
    assign w_rsp_ev   = (w_gnt & ~w_dec_ok) | w_done | w_abort;
    assign w_rsp_id   = (r_state == IDLE) ? w_gnt_id : r_id;
    assign w_rsp_err  = w_done ? APB_PSLVERR : 1'b1;
    assign w_rsp_data = (w_done && !r_write) ? APB_PRDATA : '0;

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        // Per-client response: valid pulses one cycle, data/err hold until the next one.
        always_ff @(posedge APB_CLK or negedge APB_PRESET_n) begin
            if (!APB_PRESET_n) begin
                r_rsp_valid[g] <= 1'b0;
                r_rsp_err[g]   <= 1'b0;
                r_rsp_rdata[g] <= '0;
            end else begin
                r_rsp_valid[g] <= w_rsp_ev && (w_rsp_id == 1'(g));
                if (w_rsp_ev && (w_rsp_id == 1'(g))) begin
                    r_rsp_err[g]   <= w_rsp_err;
                    r_rsp_rdata[g] <= w_rsp_data;
                end
            end
        end
    end

    assign rsp0_valid  = r_rsp_valid[0];
    assign rsp0_err    = r_rsp_err[0];
    assign rsp0_rdata  = r_rsp_rdata[0];
    assign rsp1_valid  = r_rsp_valid[1];
    assign rsp1_err    = r_rsp_err[1];
    assign rsp1_rdata  = r_rsp_rdata[1];

    assign APB_PSEL    = (r_state != IDLE);
    assign APB_PENABLE = (r_state == ACCESS);
    assign APB_PADDR   = r_addr;
    assign APB_PWRITE  = r_write;
    assign APB_PWDATA  = r_wdata;
    assign APB_PSTRB   = r_write ? r_strb : '0;

endmodule
